// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker control sequencer and its opcode classifier.
package tinker_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h2000;

  typedef enum logic [4:0] {
    OP_AND       = 5'h00, OP_OR        = 5'h01, OP_XOR       = 5'h02, OP_NOT       = 5'h03,
    OP_SHFTR     = 5'h04, OP_SHFTRI    = 5'h05, OP_SHFTL     = 5'h06, OP_SHFTLI    = 5'h07,
    OP_BR        = 5'h08, OP_BRR       = 5'h09, OP_BRR_L     = 5'h0a, OP_BRNZ      = 5'h0b,
    OP_CALL      = 5'h0c, OP_RETURN    = 5'h0d, OP_BRGT      = 5'h0e, OP_PRIV      = 5'h0f,
    OP_MOV_LOAD  = 5'h10, OP_MOV_REG   = 5'h11, OP_MOV_LIT   = 5'h12, OP_MOV_STORE = 5'h13,
    OP_ADDF      = 5'h14, OP_SUBF      = 5'h15, OP_MULF      = 5'h16, OP_DIVF      = 5'h17,
    OP_ADD       = 5'h18, OP_ADDI      = 5'h19, OP_SUB       = 5'h1a, OP_SUBI      = 5'h1b,
    OP_MUL       = 5'h1c, OP_DIV       = 5'h1d, OP_RSVD_1E   = 5'h1e, OP_RSVD_1F   = 5'h1f
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB, ST_HALT
  } state_e;

  typedef struct packed {
    logic writes_reg;
    logic is_mem;
    logic is_store;
    logic is_load;
    logic is_call;
    logic is_return;
    logic is_halt;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/tinker_op_class.sv
// Combinational opcode classifier; also reused by the decoder bench.
module tinker_op_class
  import tinker_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic       literal_zero,
  output op_class_t  cls
);

  always_comb begin
    cls            = '0;
    cls.writes_reg = (opcode <= OP_SHFTLI)
                   || (opcode >= OP_MOV_LOAD && opcode <= OP_MOV_LIT)
                   || (opcode >= OP_ADDF && opcode <= OP_DIV);
    cls.is_call    = (opcode == OP_CALL);
    cls.is_return  = (opcode == OP_RETURN);
    cls.is_store   = (opcode == OP_MOV_STORE) || cls.is_call;
    cls.is_load    = (opcode == OP_MOV_LOAD) || cls.is_return;
    cls.is_mem     = cls.is_store || cls.is_load;
    // Only "priv 0" halts; other priv literals retire as no-ops.
    cls.is_halt    = (opcode == OP_PRIV) && literal_zero;
    cls.is_illegal = (opcode == OP_RSVD_1E) || (opcode == OP_RSVD_1F);
  end

endmodule

// File: rtl/tinker_sequencer.sv
// Multi-cycle Tinker control sequencer: owns PC/IR and arbitrates one memory port
// between instruction fetch and data access.
module tinker_sequencer
  import tinker_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] instruction,
  output logic [63:0] pc,
  input  logic [63:0] data_addr,
  input  logic [63:0] store_data,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] load_data,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] load_data_q, load_data_d;
  logic        br_taken_q, br_taken_d;
  logic [63:0] br_target_q, br_target_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;

  logic        req_raw, we_raw, rw_raw;
  logic [63:0] pc_plus4;
  logic [63:0] next_pc;
  op_class_t   cls;

  tinker_op_class u_op_class (
    .opcode       (instr_q[31:27]),
    .literal_zero (instr_q[11:0] == 12'h000),
    .cls          (cls)
  );

  assign pc_plus4 = pc_q + 64'(INSTR_BYTES);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    load_data_d = load_data_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    req_raw     = 1'b0;
    we_raw      = 1'b0;
    rw_raw      = 1'b0;
    mem_addr    = pc_q;
    mem_wdata   = '0;
    next_pc     = pc_plus4;

    case (state_q)
      ST_FETCH: begin
        req_raw = 1'b1;
        if (mem_ready) begin
          instr_d = mem_rdata[31:0];
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls.is_halt || cls.is_illegal) begin
          state_d   = ST_HALT;
          halted_d  = 1'b1;
          illegal_d = cls.is_illegal;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        br_taken_d  = branch_taken;
        br_target_d = branch_target;
        state_d     = cls.is_mem ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        req_raw  = 1'b1;
        we_raw   = cls.is_store;
        mem_addr = data_addr;
        if (cls.is_store) mem_wdata = cls.is_call ? pc_plus4 : store_data;
        if (mem_ready) begin
          if (cls.is_load) load_data_d = mem_rdata;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        rw_raw = cls.writes_reg;
        if (cls.is_return)                    next_pc = load_data_q;
        else if (cls.is_call || br_taken_q)   next_pc = br_target_q;
        pc_d = next_pc;
        // A misaligned target still commits to pc so software can see where it went.
        if (next_pc[1:0] != 2'b00) begin
          state_d   = ST_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      load_data_q <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      load_data_q <= load_data_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  // Reset state is FETCH, so the strobes are masked to keep the port idle while held in reset.
  assign mem_req     = req_raw & ~reset;
  assign mem_we      = we_raw & ~reset;
  assign reg_write   = rw_raw & ~reset;
  assign wb_sel      = (instr_q[31:27] == OP_MOV_LOAD);
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign load_data   = load_data_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_tinker_sequencer.sv
// Self-checking bench for tinker_sequencer: directed scenarios followed by random instructions
// checked against an instruction-level reference model.
module tb_tinker_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic [63:0] data_addr = '0;
  logic [63:0] store_data = '0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic [63:0] load_data;
  logic        reg_write, wb_sel, halted, illegal;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] model_pc;
  bit          stopped;

  always #5 clk = ~clk;

  tinker_sequencer dut (
    .clk(clk), .reset(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instruction(instruction), .pc(pc),
    .data_addr(data_addr), .store_data(store_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .load_data(load_data), .reg_write(reg_write), .wb_sel(wb_sel),
    .halted(halted), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_pc", pc, 64'h2000);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_load_data", load_data, 64'h0);
    chk("rst_flags", {halted, illegal}, 2'b00);
    rst = 1'b0;
    #1;
    chk("rel_mem_req", mem_req, 1'b1);
    chk("rel_mem_addr", mem_addr, 64'h2000);
    model_pc = 64'h2000;
  endtask

  // Runs one instruction from its fetch cycle; the model derives everything from the opcode rules.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int dw, input logic bt,
                           input logic [63:0] btgt, input logic [63:0] daddr,
                           input logic [63:0] sdata, input logic [63:0] rdval, output bit stop);
    logic [4:0]  op;
    bit          is_halt, is_ill, is_load, is_store, is_call, is_ret, is_mem, writes;
    int          exp_cyc, req_n, waits_left, rw_cnt, rw_cyc;
    logic [63:0] npc;
    op       = ins[31:27];
    is_halt  = (op == 5'h0f) && (ins[11:0] == 12'h0);
    is_ill   = (op >= 5'h1e);
    is_call  = (op == 5'h0c);
    is_ret   = (op == 5'h0d);
    is_load  = (op == 5'h10) || is_ret;
    is_store = (op == 5'h13) || is_call;
    is_mem   = is_load || is_store;
    writes   = (op <= 5'h07) || (op >= 5'h10 && op <= 5'h12) || (op >= 5'h14 && op <= 5'h1d);
    if (is_ret) npc = rdval;
    else if (is_call || bt) npc = btgt;
    else npc = model_pc + 64'd4;
    exp_cyc = (is_halt || is_ill) ? fw + 2 : fw + 4 + (is_mem ? dw + 1 : 0);

    branch_taken  = bt;
    branch_target = btgt;
    data_addr     = daddr;
    store_data    = sdata;
    req_n = 0; waits_left = fw; rw_cnt = 0; rw_cyc = 0;

    for (int c = 1; c <= exp_cyc; c++) begin
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mem_req) begin
        if (req_n == 0) begin
          chk("fetch_addr", mem_addr, model_pc);
          chk("fetch_we", mem_we, 1'b0);
        end else begin
          chk("data_addr", mem_addr, daddr);
          chk("data_we", mem_we, is_store);
          if (is_store) chk("data_wdata", mem_wdata, is_call ? model_pc + 64'd4 : sdata);
        end
        if (waits_left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = (req_n == 0) ? {$urandom, ins} : rdval;
          req_n++;
          waits_left = dw;
        end else begin
          waits_left--;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (reg_write) begin
        rw_cnt++;
        rw_cyc = c;
        chk("wb_sel", wb_sel, op == 5'h10);
        if (op == 5'h10) chk("load_data", load_data, rdval);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;

    chk("req_count", req_n, (is_mem && !is_halt && !is_ill) ? 2 : 1);
    chk("rw_count", rw_cnt, (writes && !is_halt && !is_ill) ? 1 : 0);
    if (rw_cnt == 1) chk("rw_cycle", rw_cyc, exp_cyc);
    chk("ir", instruction, ins);
    stop = 1'b0;
    if (is_halt || is_ill) begin
      chk("halt_flags", {halted, illegal}, {1'b1, is_ill});
      chk("halt_pc", pc, model_pc);
      for (int k = 0; k < 3; k++) begin
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("halt_no_req", {mem_req, mem_we, reg_write}, 3'b000);
      end
      mem_ready = 1'b0;
      stop = 1'b1;
    end else begin
      chk("new_pc", pc, npc);
      model_pc = npc;
      if (npc[1:0] != 2'b00) begin
        chk("misalign_flags", {halted, illegal, mem_req}, 3'b110);
        stop = 1'b1;
      end else begin
        chk("next_fetch", {halted, mem_req, mem_addr}, {1'b0, 1'b1, npc});
      end
    end
    $display("[TB] op=%h pc->%h cycles=%0d halt=%0d", op, pc, exp_cyc, stop);
  endtask

  initial begin
    do_reset();

    // Reset asserted while a data read is stalled in MEM.
    mem_rdata = {32'h0, 5'h10, 27'h0};
    data_addr = 64'h100;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_mem_req", mem_req, 1'b1);
    chk("mid_mem_addr", mem_addr, 64'h100);
    rst = 1'b1;
    #1;
    chk("abort_req", {mem_req, mem_we, reg_write}, 3'b000);
    chk("abort_pc", pc, 64'h2000);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_abort_req", mem_req, 1'b1);
    chk("post_abort_addr", mem_addr, 64'h2000);
    model_pc = 64'h2000;

    // add, mem_ready immediate
    run_instr({5'h18, 27'h0}, 0, 0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, stopped);
    // load with 3 fetch waits and 2 data waits
    run_instr({5'h10, 27'h0}, 3, 2, 1'b0, 64'h0, 64'h100, 64'h0, 64'hDEAD, stopped);
    // store
    run_instr({5'h13, 27'h0}, 1, 1, 1'b0, 64'h0, 64'h240, 64'h1234_5678_9abc_def0, 64'h0, stopped);

    // call/return pair from 0x2000
    do_reset();
    run_instr({5'h0c, 27'h0}, 0, 0, 1'b0, 64'h3000, 64'hFFF8, 64'h0, 64'h0, stopped);
    run_instr({5'h0d, 27'h0}, 0, 1, 1'b0, 64'h0, 64'hFFF8, 64'h0, 64'h2004, stopped);

    // halt, illegal opcode, misaligned branch target
    run_instr({5'h0f, 27'h0}, 0, 0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, stopped);
    do_reset();
    run_instr({5'h1f, 27'h0}, 1, 0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, stopped);
    do_reset();
    run_instr({5'h08, 27'h0}, 0, 0, 1'b1, 64'h3002, 64'h0, 64'h0, 64'h0, stopped);
    do_reset();

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ins;
      logic [63:0] tgt, rv;
      ins = $urandom;
      if (ins[31:27] == 5'h0f && $urandom_range(0, 3) != 0) ins[11:0] = 12'h001;
      tgt = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 15) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      rv = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 15) == 0) rv[0] = 1'b1;
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                tgt, {$urandom, $urandom}, {$urandom, $urandom}, rv, stopped);
      if (stopped) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
